// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and registered HI/LO results.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_zero_q, div_zero_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     rem_shift;
    logic               rem_ge;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        dz_d       = dz_q;
        a_d        = a_q;
        b_d        = b_q;
        rem_d      = rem_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;

        // Divide: a_q shifts the dividend out at the top and the quotient in at the bottom.
        rem_shift = {rem_q, a_q[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, b_q});
        // Multiply: add into the upper half, then shift the whole accumulator right.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);

        prod_fix = (s1_q ^ s2_q) ? -acc_q : acc_q;
        quo_fix  = (s1_q ^ s2_q) ? -a_q : a_q;
        rem_fix  = s1_q ? -rem_q : rem_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    is_div_d = op_i[1];
                    s1_d     = op_i[0] & src1_i[WIDTH-1];
                    s2_d     = op_i[0] & src2_i[WIDTH-1];
                    a_d      = s1_d ? -src1_i : src1_i;
                    b_d      = s2_d ? -src2_i : src2_i;
                    dz_d     = op_i[1] && (src2_i == '0);
                    rem_d    = '0;
                    acc_d    = '0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    rem_d = rem_ge ? WIDTH'(rem_shift - {1'b0, b_q}) : rem_shift[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], rem_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    b_d   = b_q >> 1;
                end
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d    = S_IDLE;
                done_d     = 1'b1;
                div_zero_d = dz_q;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (dz_q) begin
                    // Zero divisor: the remainder has collected the captured dividend.
                    hi_d = rem_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            dz_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            dz_q       <= dz_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: scoreboard of expected HI/LO/div-zero
// results drained by a monitor on done_o, plus directed timing/hazard checks.
module tb_mul_div_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_zero_o;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .div_zero_o (div_zero_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: plain 64-bit arithmetic on the operands as the ISA defines them.
    function automatic exp_t refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        logic [63:0] up;
        logic signed [63:0] pa, pb, sp, sq, sr;
        pa = {{32{a[31]}}, a};
        pb = {{32{b[31]}}, b};
        r.dz = 1'b0;
        case (op)
            2'd0: begin
                up = {32'd0, a} * {32'd0, b};
                r.hi = up[63:32];
                r.lo = up[31:0];
            end
            2'd1: begin
                sp = pa * pb;
                r.hi = sp[63:32];
                r.lo = sp[31:0];
            end
            2'd2: begin
                if (b == 32'd0) begin
                    r.hi = a;
                    r.lo = 32'hFFFF_FFFF;
                    r.dz = 1'b1;
                end else begin
                    r.hi = a % b;
                    r.lo = a / b;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    r.hi = a[31] ? -a : a;
                    r.lo = 32'hFFFF_FFFF;
                    r.dz = 1'b1;
                end else begin
                    sq = pa / pb;
                    sr = pa % pb;
                    r.hi = sr[31:0];
                    r.lo = sq[31:0];
                end
            end
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (!rst_i && done_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done actual=done required=no_done at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("hi", hi_o, mon_e.hi);
                checkOutput("lo", lo_o, mon_e.lo);
                checkOutput("div_zero", {31'd0, div_zero_o}, {31'd0, mon_e.dz});
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = op;
        src1_i  = a;
        src2_i  = b;
        exp_q.push_back(refModel(op, a, b));
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Called on the negedge after the start edge; cyc counts edges since that start edge.
    task automatic waitDone(output int cyc, output int busy_cnt);
        cyc      = 0;
        busy_cnt = busy_o ? 1 : 0;
        while (!done_o && cyc < 60) begin
            @(negedge clk_i);
            cyc++;
            if (busy_o) busy_cnt++;
        end
        if (!done_o) begin
            total++;
            bad++;
            $display("[TB] FAIL done_timeout actual=none required=done_o within 60 cycles");
        end
    endtask

    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int c, bc;
        applyStimulus(op, a, b);
        waitDone(c, bc);
        checkOutput("latency", c, 33);
        @(negedge clk_i);
    endtask

    task automatic countDones(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk_i);
            if (done_o) n++;
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int c, bc, gap, n;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        rst_i   = 1'b1;
        start_i = 1'b0;
        op_i    = 2'd0;
        src1_i  = '0;
        src2_i  = '0;
        repeat (3) @(negedge clk_i);
        checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("rst_done", {31'd0, done_o}, 32'd0);
        checkOutput("rst_hi", hi_o, 32'd0);
        checkOutput("rst_lo", lo_o, 32'd0);
        checkOutput("rst_dz", {31'd0, div_zero_o}, 32'd0);
        rst_i = 1'b0;

        applyStimulus(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone(c, bc);
        checkOutput("multu_latency", c, 33);
        checkOutput("multu_busy_cycles", bc, 33);
        @(negedge clk_i);
        checkOutput("done_one_cycle", {31'd0, done_o}, 32'd0);
        checkOutput("hold_hi", hi_o, 32'hFFFF_FFFE);

        runOp(2'd1, -32'sd3, 32'd7);
        runOp(2'd3, -32'sd7, 32'd2);
        runOp(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        runOp(2'd2, 32'd100, 32'd0);
        runOp(2'd2, 32'd100, 32'd7);

        // Start pulse mid-RUN must be ignored; old result must hold meanwhile.
        applyStimulus(2'd0, 32'd5, 32'd6);
        repeat (4) @(negedge clk_i);
        checkOutput("hold_lo_during_run", lo_o, 32'd14);
        start_i = 1'b1;
        op_i    = 2'd2;
        src1_i  = 32'd999;
        src2_i  = 32'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        waitDone(c, bc);
        checkOutput("ignored_start_latency", c, 33 - 5);
        countDones(40, n);
        checkOutput("ignored_start_no_extra_done", n, 0);

        // Reset in cycle 10 of a MULT aborts it.
        applyStimulus(2'd1, 32'h1234_5678, 32'hFEDC_BA98);
        repeat (9) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_q.delete();
        checkOutput("abort_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("abort_hi", hi_o, 32'd0);
        checkOutput("abort_lo", lo_o, 32'd0);
        checkOutput("abort_dz", {31'd0, div_zero_o}, 32'd0);
        countDones(40, n);
        checkOutput("abort_no_done", n, 0);
        runOp(2'd1, 32'd12, -32'sd12);

        // Start held through done: second op captured in the done cycle.
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = 2'd0;
        src1_i  = 32'd1234;
        src2_i  = 32'd5678;
        exp_q.push_back(refModel(2'd0, 32'd1234, 32'd5678));
        @(negedge clk_i);
        waitDone(c, bc);
        checkOutput("b2b_first_latency", c, 33);
        op_i   = 2'd3;
        src1_i = -32'sd1000;
        src2_i = 32'd7;
        exp_q.push_back(refModel(2'd3, -32'sd1000, 32'd7));
        gap = 0;
        @(negedge clk_i);
        start_i = 1'b0;
        gap = 1;
        while (!done_o && gap < 60) begin
            @(negedge clk_i);
            gap++;
        end
        checkOutput("b2b_spacing", gap, 34);
        @(negedge clk_i);

        for (int i = 0; i < 25; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pickOperand();
            rb  = pickOperand();
            if (rop == 2'd3 && rb == 32'd0) ra = ra & 32'h7FFF_FFFF;
            runOp(rop, ra, rb);
        end

        repeat (3) @(negedge clk_i);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit for the CPU datapath; runs MULT, MULTU, DIV and DIVU over a fixed number of cycles and holds the HI/LO result pair in registers. It sits directly upstream of the writeback-select 4-to-1 multiplexer: `lo_o` or `hi_o` drives one data input of that mux. The control unit uses `start_i`, `busy_o` and `done_o` to stall the pipeline while an operation is in flight.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits. Iteration count equals `WIDTH`.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous and active-high.
- `start_i` input 1: launch request. Sampled only in IDLE.
- `op_i` input 2: operation select. 00 MULTU, 01 MULT, 10 DIVU, 11 DIV. Sampled with `start_i`.
- `src1_i` input WIDTH: multiplicand or dividend. Sampled with `start_i`.
- `src2_i` input WIDTH: multiplier or divisor. Sampled with `start_i`.
- `busy_o` output 1: high in the RUN and FIX states.
- `done_o` output 1: registered one-cycle completion pulse.
- `hi_o` output WIDTH: upper product half, or remainder.
- `lo_o` output WIDTH: lower product half, or quotient.
- `div_zero_o` output 1: set with `done_o` when a divide had divisor 0; held until the next completion.

## Operation
- **States:**
  - IDLE → RUN when `start_i` is sampled high in IDLE.
  - RUN → FIX after `WIDTH` iterations.
  - FIX → IDLE unconditionally.
- **Capture (edge E0, IDLE with `start_i`=1):**
  - Latch `op_i` and the operands. For signed ops, store absolute values and record the operand signs.
  - Clear the iteration counter and the accumulators.
- **RUN, one iteration per edge, E1..E_WIDTH:**
  - Multiply: shift-add, one multiplier bit per cycle, into a 2·WIDTH unsigned accumulator.
  - Divide: restoring division, one quotient bit per cycle. The partial remainder has WIDTH+1 bits so the subtract-compare does not overflow.
- **FIX (edge E_{WIDTH+1}):** apply sign correction, load `hi_o`/`lo_o`, set `done_o`, return to IDLE.
  - MULT: negate the 2·WIDTH product when the operand signs differ.
  - DIV: quotient sign = sign(src1) XOR sign(src2). Remainder sign = sign(src1).
  - Unsigned ops: no correction.
- **Divide by zero** (divisor 0, DIVU or DIV):
  - Result: `lo_o` = all ones, `hi_o` = dividend as captured (no sign correction), `div_zero_o` = 1.
  - Latency is unchanged.
- **Signed overflow:** DIV of most-negative by −1 gives `lo_o` = most-negative and `hi_o` = 0. No flag is raised.
- **Start while busy:** `start_i` in RUN or FIX is ignored. It is not queued.
- **Result hold:** `hi_o`, `lo_o` and `div_zero_o` hold their values until the next FIX edge. Launching a new operation does not disturb them.
- **Reset:** all registers clear, state goes to IDLE. `busy_o`, `done_o`, `div_zero_o` = 0 and `hi_o`, `lo_o` = 0.
  - Reset mid-operation aborts the operation. No `done_o` is produced and the operation does not resume.

## Timing
- `busy_o` rises after E0 and falls after E_{WIDTH+1}. That is `WIDTH`+1 cycles high (33 at default).
- `done_o` is high for exactly the one cycle following E_{WIDTH+1}, which is `WIDTH`+1 cycles after the start edge.
  - In that cycle the state is IDLE and the new `hi_o`/`lo_o` are valid.
- **Back-to-back:** a `start_i` sampled during the `done_o` cycle is accepted. Minimum start-to-start spacing is `WIDTH`+2 edges.
- **Latency:** fixed for every op and operand value. There is no early termination.
- **Outputs:** all outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF → `hi_o`=0xFFFFFFFE, `lo_o`=0x00000001. `done_o` pulses exactly 33 cycles after the start edge; `busy_o` is high for 33 cycles.
- **MULT:** −3 × 7 → `hi_o`=0xFFFFFFFF, `lo_o`=0xFFFFFFEB.
- **DIV:** −7 ÷ 2 → `lo_o`=0xFFFFFFFD, `hi_o`=0xFFFFFFFF.
- **DIV overflow:** 0x80000000 ÷ 0xFFFFFFFF → `lo_o`=0x80000000, `hi_o`=0, `div_zero_o`=0.
- **DIVU by zero:** 100 ÷ 0 → `lo_o`=0xFFFFFFFF, `hi_o`=0x00000064, `div_zero_o`=1 with `done_o`. Then DIVU 100 ÷ 7 → `lo_o`=14, `hi_o`=2, `div_zero_o`=0.
- **Control hazards:**
  - `start_i` pulsed mid-RUN with different operands is ignored, and the result matches the first op.
  - `rst_i` asserted at cycle 10 of a MULT: no `done_o` appears, all outputs read 0, and the next start completes normally.
  - `start_i` held high through a `done_o` cycle gives back-to-back completions 34 cycles apart.
